// File: rtl/priority_decoder_seq_pkg.sv
// Shared definitions for the priority encoder link: FSM states, code-to-line
// constants and the one-hot decode used by the receiving end.
package priority_decoder_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    localparam logic [1:0] CODE_A = 2'b11;
    localparam logic [1:0] CODE_B = 2'b10;
    localparam logic [1:0] CODE_C = 2'b01;
    localparam logic [1:0] CODE_D = 2'b00;

    // Returns {a,b,c,d}; a null word (p=0) decodes to all-zero.
    function automatic logic [3:0] decode_word(input logic p, input logic [1:0] code);
        logic [3:0] lines;
        lines = 4'b0000;
        if (p) begin
            case (code)
                CODE_A:  lines = 4'b1000;
                CODE_B:  lines = 4'b0100;
                CODE_C:  lines = 4'b0010;
                default: lines = 4'b0001;
            endcase
        end
        return lines;
    endfunction

endpackage

// File: rtl/priority_decoder_seq_hold_timer.sv
// Load/terminal-count down-counter timing the HOLD and GAP phases.
// Loaded with N-1, tc is high in the last cycle of an N-cycle phase.
module hold_timer #(
    parameter int TW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          tc
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TW'(1);
        end
    end

    assign tc = (cnt_q == '0);

endmodule

// File: rtl/priority_decoder_seq.sv
// Receiving end of the 4-line priority encoder link: decodes {p,q,r} into
// one-hot pulses of fixed width with an optional zero gap, one word buffered.
module priority_decoder_seq
    import priority_decoder_seq_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             p,
    input  logic             q,
    input  logic             r,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic [CNT_W-1:0] evt_cnt
);

    localparam int MAX_D = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int TW    = $clog2(MAX_D + 1);
    localparam logic [TW-1:0] HOLD_V = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] GAP_V  = TW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    state_t          state_q, state_d;
    logic [3:0]      lines_q, lines_d;
    logic            pend_vld;
    logic            pend_p;
    logic [1:0]      pend_code;
    logic            accept;
    logic            slot_end;
    logic            direct;
    logic            pend_store;
    logic            pend_take;
    logic            tmr_load;
    logic [TW-1:0]   tmr_val;
    logic            tmr_tc;

    assign in_ready   = !rst && !pend_vld;
    assign accept     = in_valid && in_ready;
    assign busy       = (state_q != ST_IDLE) || pend_vld;
    assign {a, b, c, d} = lines_q;

    hold_timer #(.TW(TW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d   = state_q;
        lines_d   = lines_q;
        tmr_load  = 1'b0;
        tmr_val   = HOLD_V;
        pend_take = 1'b0;
        slot_end  = 1'b0;
        direct    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    direct = 1'b1;
                end
            end
            ST_HOLD: begin
                if (tmr_tc) begin
                    if (GAP_CYCLES > 0) begin
                        lines_d  = 4'b0000;
                        state_d  = ST_GAP;
                        tmr_load = 1'b1;
                        tmr_val  = GAP_V;
                    end else begin
                        slot_end = 1'b1;
                    end
                end
            end
            ST_GAP: begin
                if (tmr_tc) begin
                    slot_end = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                lines_d = 4'b0000;
            end
        endcase

        // A slot boundary either starts the pending word, starts a word arriving
        // right now (pend empty, so it never needs buffering), or goes idle.
        if (slot_end) begin
            if (pend_vld) begin
                lines_d   = decode_word(pend_p, pend_code);
                state_d   = ST_HOLD;
                tmr_load  = 1'b1;
                tmr_val   = HOLD_V;
                pend_take = 1'b1;
            end else if (accept) begin
                direct = 1'b1;
            end else begin
                lines_d = 4'b0000;
                state_d = ST_IDLE;
            end
        end

        if (direct) begin
            lines_d  = decode_word(p, {q, r});
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
            tmr_val  = HOLD_V;
        end
    end

    assign pend_store = accept && !direct;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            lines_q  <= 4'b0000;
            pend_vld <= 1'b0;
            evt_cnt  <= '0;
        end else begin
            state_q <= state_d;
            lines_q <= lines_d;
            if (pend_take) begin
                pend_vld <= 1'b0;
            end else if (pend_store) begin
                pend_vld <= 1'b1;
            end
            if (accept && p && (evt_cnt != {CNT_W{1'b1}})) begin
                evt_cnt <= evt_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pend_store) begin
            pend_p    <= p;
            pend_code <= {q, r};
        end
    end

endmodule

// File: tb/tb_priority_decoder_seq.sv
// Bench for priority_decoder_seq: three configurations driven by shared
// stimulus, each compared against a slot-scheduling reference model.
module tb_priority_decoder_seq;

    localparam int NI = 3;
    localparam int HOLD_P [NI] = '{4, 4, 4};
    localparam int GAP_P  [NI] = '{1, 0, 1};
    localparam int CMAX_P [NI] = '{255, 255, 3};

    logic clk = 1'b0;
    logic rst, in_valid, p, q, r;
    logic rdy0, rdy1, rdy2;
    logic bsy0, bsy1, bsy2;
    logic [3:0] ln0, ln1, ln2;
    logic [7:0] evt0, evt1;
    logic [1:0] evt2;

    always #5 clk = ~clk;

    priority_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(8)) u0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
        .p(p), .q(q), .r(r), .a(ln0[3]), .b(ln0[2]), .c(ln0[1]), .d(ln0[0]),
        .busy(bsy0), .evt_cnt(evt0));

    priority_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(0), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
        .p(p), .q(q), .r(r), .a(ln1[3]), .b(ln1[2]), .c(ln1[1]), .d(ln1[0]),
        .busy(bsy1), .evt_cnt(evt1));

    priority_decoder_seq #(.HOLD_CYCLES(4), .GAP_CYCLES(1), .CNT_W(2)) u2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
        .p(p), .q(q), .r(r), .a(ln2[3]), .b(ln2[2]), .c(ln2[1]), .d(ln2[0]),
        .busy(bsy2), .evt_cnt(evt2));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model: every accepted word owns a slot starting at
    // max(accept edge, end of previous slot); a slot is HOLD line cycles then GAP zeros.
    int         free_m     [NI];
    int         last_start [NI];
    int         evt_m      [NI];
    int         sl_start   [NI][2];
    logic [3:0] sl_line    [NI][2];
    bit         sl_vld     [NI][2];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic bit ready_m(input int i);
        return !rst && !(cyc < last_start[i]);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NI; i++) begin
            free_m[i] = 0;
            last_start[i] = 0;
            evt_m[i] = 0;
            for (int k = 0; k < 2; k++) begin
                sl_vld[i][k] = 1'b0;
                sl_start[i][k] = 0;
                sl_line[i][k] = 4'b0000;
            end
        end
    endtask

    // Called just after an edge; inputs still hold the values seen at that edge.
    task automatic model_edge(input bit acc_ok [NI]);
        int e;
        int st;
        e = cyc + 1;
        if (rst) begin
            model_reset();
        end else begin
            for (int i = 0; i < NI; i++) begin
                if (in_valid && acc_ok[i]) begin
                    st = (e > free_m[i]) ? e : free_m[i];
                    sl_vld[i][0]   = sl_vld[i][1];
                    sl_start[i][0] = sl_start[i][1];
                    sl_line[i][0]  = sl_line[i][1];
                    sl_vld[i][1]   = 1'b1;
                    sl_start[i][1] = st;
                    sl_line[i][1]  = p ? (4'b0001 << {q, r}) : 4'b0000;
                    free_m[i]      = st + HOLD_P[i] + GAP_P[i];
                    last_start[i]  = st;
                    if (p && evt_m[i] < CMAX_P[i]) evt_m[i]++;
                end
            end
        end
        cyc = e;
    endtask

    task automatic check_cycle();
        logic [3:0] exp_ln;
        logic [3:0] got_ln;
        logic       got_rdy, got_bsy;
        logic [7:0] got_evt;
        for (int i = 0; i < NI; i++) begin
            exp_ln = 4'b0000;
            for (int k = 0; k < 2; k++)
                if (sl_vld[i][k] && sl_start[i][k] <= cyc && cyc < sl_start[i][k] + HOLD_P[i])
                    exp_ln = sl_line[i][k];
            case (i)
                0:       begin got_ln = ln0; got_rdy = rdy0; got_bsy = bsy0; got_evt = evt0; end
                1:       begin got_ln = ln1; got_rdy = rdy1; got_bsy = bsy1; got_evt = evt1; end
                default: begin got_ln = ln2; got_rdy = rdy2; got_bsy = bsy2; got_evt = {6'b0, evt2}; end
            endcase
            chk($sformatf("lines%0d", i), {28'b0, got_ln}, {28'b0, exp_ln});
            chk($sformatf("onehot%0d", i), {31'b0, ($countones(got_ln) <= 1)}, 32'd1);
            chk($sformatf("in_ready%0d", i), {31'b0, got_rdy}, {31'b0, ready_m(i)});
            chk($sformatf("busy%0d", i), {31'b0, got_bsy}, {31'b0, (cyc < free_m[i])});
            chk($sformatf("evt_cnt%0d", i), {24'b0, got_evt}, evt_m[i]);
        end
    endtask

    // One cycle: drive, check the current cycle mid-period, then advance.
    task automatic step(input bit rst_i, input bit vld_i, input bit [2:0] w);
        bit acc_ok [NI];
        rst = rst_i;
        in_valid = vld_i;
        {p, q, r} = w;
        @(negedge clk);
        check_cycle();
        for (int i = 0; i < NI; i++) acc_ok[i] = ready_m(i);
        @(posedge clk);
        model_edge(acc_ok);
        #1;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        {p, q, r} = 3'b000;
        @(posedge clk);
        @(posedge clk);
        #1;
        model_reset();

        // reset held, then a single 'a' word
        step(1'b1, 1'b0, 3'b000);
        step(1'b0, 1'b1, 3'b111);
        idle(8);
        // 'b' then 'c' two cycles later, buffered behind the first
        step(1'b0, 1'b1, 3'b110);
        idle(1);
        step(1'b0, 1'b1, 3'b101);
        idle(12);
        // null word still occupies a slot
        step(1'b0, 1'b1, 3'b011);
        idle(7);
        // reset mid-hold with the pending word full
        step(1'b0, 1'b1, 3'b111);
        step(1'b0, 1'b1, 3'b110);
        idle(1);
        step(1'b1, 1'b0, 3'b000);
        idle(3);
        // saturation on the narrow counter, back-to-back on the gapless one
        for (int k = 0; k < 5; k++) begin
            step(1'b0, 1'b1, 3'b100);
            step(1'b0, 1'b1, 3'b111);
            idle(3);
        end
        idle(12);

        for (int k = 0; k < 4000; k++) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), 3'($urandom));
        end
        idle(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
